// File: rtl/ddr4_ca_lane_tx_ctrl.sv
// ddr4_ca_lane_tx_ctrl
// Fabric-side driver for one DDR4 command/address output lane on a 4:1 IOD.
// It registers the four command phases into the IOD TX/OE data inputs. It also
// sequences the lane's dynamic output delay line (move/direction/load) for CA
// training, and keeps the lane idle while the delay line is changing.
//
// Ports
//   fab_clk, arst_n          fabric clock (same as IOD TX_CLK), async active-low reset
//   cmd_valid/cmd_ready      command handshake; accepted when both are high at a rising edge
//   cmd_data[3:0]            phase bits, bit 0 transmitted first
//   output_en                1 = drive pad, 0 = tristate
//   tx_data_0, oe_data_0     registered IOD data / output-enable phases
//   dly_req/dly_dir/dly_steps   relative delay move request (sampled only when idle)
//   dly_load_req             reload delay line to DEFAULT_TAP (wins over dly_req)
//   dly_busy/dly_done/dly_err   delay sequencer status
//   tap_count[7:0]           current tap estimate
//   delay_line_*_0           IOD delay-line controls and the out-of-range flag
module ddr4_ca_lane_tx_ctrl #(
   parameter logic        IDLE_LEVEL  = 1'b1,
   parameter int unsigned TAP_MAX     = 127,
   parameter int unsigned DEFAULT_TAP = 1,
   parameter int unsigned MOVE_GAP    = 3
) (
   input  logic       fab_clk,
   input  logic       arst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_data,
   input  logic       output_en,
   output logic [3:0] tx_data_0,
   output logic [3:0] oe_data_0,
   input  logic       dly_req,
   input  logic       dly_dir,
   input  logic [7:0] dly_steps,
   input  logic       dly_load_req,
   output logic       dly_busy,
   output logic       dly_done,
   output logic       dly_err,
   output logic [7:0] tap_count,
   output logic       delay_line_move_0,
   output logic       delay_line_direction_0,
   output logic       delay_line_load_0,
   input  logic       delay_line_out_of_range_0
);

   localparam logic [7:0] TAP_MAX_C     = 8'(TAP_MAX);
   localparam logic [7:0] DEFAULT_TAP_C = 8'(DEFAULT_TAP);
   localparam logic [7:0] GAP_LAST_C    = 8'(MOVE_GAP - 1);
   localparam logic [3:0] IDLE_WORD_C   = {4{IDLE_LEVEL}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRAIN = 3'd1,
      ST_MOVE  = 3'd2,
      ST_GAP   = 3'd3,
      ST_LOAD  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t     state_r, state_s;
   logic       dir_r, dir_s;
   logic       err_r, err_s;
   logic [7:0] tap_r, tap_s;
   logic [7:0] remaining_r, remaining_s;
   logic [7:0] gap_cnt_r, gap_cnt_s;
   logic       at_limit_s;
   logic       cmd_accept_s;

   // Another tap in the latched direction would leave the legal range.
   assign at_limit_s   = dir_r ? (tap_r == TAP_MAX_C) : (tap_r == 8'd0);
   // A command is never taken on the same edge as a delay request. This keeps the
   // lane idle for the whole cycle before the delay line is touched.
   assign cmd_ready    = (state_r == ST_IDLE) & ~dly_req & ~dly_load_req;
   assign cmd_accept_s = cmd_valid & cmd_ready;

   // Delay sequencer next-state and next-register values.
   always_comb begin
      state_s     = state_r;
      dir_s       = dir_r;
      err_s       = err_r;
      tap_s       = tap_r;
      remaining_s = remaining_r;
      gap_cnt_s   = gap_cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (dly_load_req) begin
               state_s = ST_LOAD;
            end else if (dly_req) begin
               if (dly_steps == 8'd0) begin
                  // A zero-step request completes at once and leaves the error flag unchanged.
                  state_s = ST_DONE;
               end else begin
                  state_s     = ST_DRAIN;
                  dir_s       = dly_dir;
                  remaining_s = dly_steps;
                  err_s       = 1'b0;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            state_s = ST_MOVE;
         end
         ST_MOVE: begin
            if (at_limit_s) begin
               err_s   = 1'b1;
               state_s = ST_DONE;
            end else begin
               tap_s       = dir_r ? (tap_r + 8'd1) : (tap_r - 8'd1);
               remaining_s = remaining_r - 8'd1;
               gap_cnt_s   = GAP_LAST_C;
               state_s     = ST_GAP;
            end
         end
         ST_GAP: begin
            if (delay_line_out_of_range_0) begin
               err_s   = 1'b1;
               state_s = ST_DONE;
            end else if (gap_cnt_r == 8'd0) begin
               state_s = (remaining_r == 8'd0) ? ST_DONE : ST_MOVE;
            end else begin
               gap_cnt_s = gap_cnt_r - 8'd1;
            end
         end
         ST_LOAD: begin
            tap_s       = DEFAULT_TAP_C;
            err_s       = 1'b0;
            remaining_s = 8'd0;
            gap_cnt_s   = GAP_LAST_C;
            state_s     = ST_GAP;
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Delay sequencer state and bookkeeping registers.
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r     <= ST_IDLE;
         dir_r       <= 1'b0;
         err_r       <= 1'b0;
         tap_r       <= DEFAULT_TAP_C;
         remaining_r <= 8'd0;
         gap_cnt_r   <= 8'd0;
      end else begin
         state_r     <= state_s;
         dir_r       <= dir_s;
         err_r       <= err_s;
         tap_r       <= tap_s;
         remaining_r <= remaining_s;
         gap_cnt_r   <= gap_cnt_s;
      end
   end

   // Single register stage feeding the IOD data and output-enable phases.
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         tx_data_0 <= IDLE_WORD_C;
         oe_data_0 <= 4'b0000;
      end else begin
         tx_data_0 <= cmd_accept_s ? cmd_data : IDLE_WORD_C;
         oe_data_0 <= output_en ? 4'b1111 : 4'b0000;
      end
   end

   // Status and delay-line controls are decoded only from registered state.
   assign delay_line_move_0      = (state_r == ST_MOVE) & ~at_limit_s;
   assign delay_line_load_0      = (state_r == ST_LOAD);
   assign delay_line_direction_0 = dir_r;
   assign dly_busy               = (state_r != ST_IDLE);
   assign dly_done               = (state_r == ST_DONE);
   assign dly_err                = err_r;
   assign tap_count              = tap_r;

endmodule

// File: tb/tb_ddr4_ca_lane_tx_ctrl.sv
module tb_ddr4_ca_lane_tx_ctrl;

   localparam int TAP_MAX     = 127;
   localparam int DEFAULT_TAP = 1;
   localparam int MOVE_GAP    = 3;
   localparam int PERIOD      = 1 + MOVE_GAP;
   localparam logic [3:0] IDLE_W = 4'b1111;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_data = 4'd0;
   logic       output_en = 1'b0;
   logic [3:0] tx_data_0;
   logic [3:0] oe_data_0;
   logic       dly_req = 1'b0;
   logic       dly_dir = 1'b0;
   logic [7:0] dly_steps = 8'd0;
   logic       dly_load_req = 1'b0;
   logic       dly_busy;
   logic       dly_done;
   logic       dly_err;
   logic [7:0] tap_count;
   logic       move_0;
   logic       dir_0;
   logic       load_0;
   logic       oor = 1'b0;

   int errors = 0;
   int checks = 0;
   int model_tap;
   int model_err;

   ddr4_ca_lane_tx_ctrl #(
      .IDLE_LEVEL(1'b1), .TAP_MAX(TAP_MAX), .DEFAULT_TAP(DEFAULT_TAP), .MOVE_GAP(MOVE_GAP)
   ) dut (
      .fab_clk(clk), .arst_n(arst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .output_en(output_en), .tx_data_0(tx_data_0), .oe_data_0(oe_data_0),
      .dly_req(dly_req), .dly_dir(dly_dir), .dly_steps(dly_steps),
      .dly_load_req(dly_load_req), .dly_busy(dly_busy), .dly_done(dly_done),
      .dly_err(dly_err), .tap_count(tap_count),
      .delay_line_move_0(move_0), .delay_line_direction_0(dir_0),
      .delay_line_load_0(load_0), .delay_line_out_of_range_0(oor)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values();
      chk("rst_tx", 32'(tx_data_0), 32'(IDLE_W));
      chk("rst_oe", 32'(oe_data_0), 32'd0);
      chk("rst_move", 32'(move_0), 32'd0);
      chk("rst_load", 32'(load_0), 32'd0);
      chk("rst_dir", 32'(dir_0), 32'd0);
      chk("rst_busy", 32'(dly_busy), 32'd0);
      chk("rst_done", 32'(dly_done), 32'd0);
      chk("rst_err", 32'(dly_err), 32'd0);
      chk("rst_tap", 32'(tap_count), 32'(DEFAULT_TAP));
   endtask

   // One fabric cycle of traffic with the delay sequencer idle.
   task automatic dp_step(input logic v, input logic [3:0] d, input logic oe);
      @(negedge clk);
      cmd_valid = v; cmd_data = d; output_en = oe;
      @(posedge clk);
      #1;
      chk("dp_tx", 32'(tx_data_0), 32'(v ? d : IDLE_W));
      chk("dp_oe", 32'(oe_data_0), 32'(oe ? 4'b1111 : 4'b0000));
   endtask

   // Issue one delay operation while commands are offered every cycle, then check it
   // against timing that is computed from the start tap, direction and step count.
   task automatic run_op(input bit req, input bit ld, input bit dir, input int steps,
                         input int oor_j);
      int exp_pulses, exp_done, exp_err, exp_tap, lim, pulses, done_c;
      pulses = 0;
      done_c = -1;
      lim = dir ? (TAP_MAX - model_tap) : model_tap;
      if (ld) begin
         exp_pulses = 0; exp_done = 2 + MOVE_GAP; exp_err = 0; exp_tap = DEFAULT_TAP;
      end else if (steps == 0) begin
         exp_pulses = 0; exp_done = 1; exp_err = model_err; exp_tap = model_tap;
      end else if (oor_j >= 0) begin
         exp_pulses = oor_j + 1; exp_done = 4 + oor_j * PERIOD; exp_err = 1;
         exp_tap = dir ? model_tap + exp_pulses : model_tap - exp_pulses;
      end else if (steps <= lim) begin
         exp_pulses = steps; exp_done = 2 + steps * PERIOD; exp_err = 0;
         exp_tap = dir ? model_tap + steps : model_tap - steps;
      end else begin
         exp_pulses = lim; exp_done = 3 + lim * PERIOD; exp_err = 1;
         exp_tap = dir ? TAP_MAX : 0;
      end

      @(negedge clk);
      cmd_valid = 1'b1; cmd_data = 4'($urandom);
      dly_req = req; dly_load_req = ld; dly_dir = dir; dly_steps = 8'(steps);
      #1;
      chk("ready_with_req", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      dly_req = 1'b0; dly_load_req = 1'b0;
      dly_dir = 1'($urandom); dly_steps = 8'($urandom);
      for (int c = 1; c <= 1200; c++) begin
         if (c > 1) @(negedge clk);
         cmd_data = 4'($urandom);
         if (!ld && oor_j >= 0 && c == 3 + oor_j * PERIOD) oor = 1'b1;
         if (move_0) begin
            chk("pulse_offset", 32'(c), 32'(2 + pulses * PERIOD));
            chk("pulse_dir", 32'(dir_0), 32'(dir));
            pulses++;
         end
         if (load_0) chk("load_offset", 32'(c), 32'(ld ? 1 : 0));
         chk("tx_idle_busy", 32'(tx_data_0), 32'(IDLE_W));
         if (dly_done) begin
            done_c = c;
            break;
         end
         chk("busy", 32'(dly_busy), 32'd1);
      end
      oor = 1'b0;
      chk("done_offset", 32'(done_c), 32'(exp_done));
      chk("pulse_count", 32'(pulses), 32'(exp_pulses));
      chk("err", 32'(dly_err), 32'(exp_err));
      chk("tap", 32'(tap_count), 32'(exp_tap));
      model_tap = exp_tap;
      model_err = exp_err;
      @(negedge clk);
      chk("idle_busy", 32'(dly_busy), 32'd0);
      chk("idle_done", 32'(dly_done), 32'd0);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int pulses_seen;
      bit ld;
      bit dir;
      int steps;
      int oj;
      int lim;
      int m;

      // Reset state, with output_en high so the OE reset value is visible.
      output_en = 1'b1;
      cmd_valid = 1'b1;
      cmd_data = 4'b0000;
      repeat (3) @(negedge clk);
      chk_reset_values();
      arst_n = 1'b1;
      model_tap = DEFAULT_TAP;
      model_err = 0;

      // Directed pattern: 0101 offered for 3 cycles, then nothing.
      dp_step(1'b1, 4'b0101, 1'b1);
      dp_step(1'b1, 4'b0101, 1'b1);
      dp_step(1'b1, 4'b0101, 1'b0);
      dp_step(1'b0, 4'b0101, 1'b0);
      dp_step(1'b0, 4'b0000, 1'b1);

      // Random traffic, back to back.
      for (int i = 0; i < 20; i++) dp_step(1'($urandom), 4'($urandom), 1'($urandom));

      // Up 3 from tap 1.
      run_op(1'b1, 1'b0, 1'b1, 3, -1);
      // Reload, then down 5 from tap 1 hits the lower limit.
      run_op(1'b0, 1'b1, 1'b0, 0, -1);
      run_op(1'b1, 1'b0, 1'b0, 5, -1);
      // Zero-step request leaves the error flag set.
      run_op(1'b1, 1'b0, 1'b1, 0, -1);
      // Out-of-range during the first gap of an 8-step move.
      run_op(1'b0, 1'b1, 1'b0, 0, -1);
      run_op(1'b1, 1'b0, 1'b1, 8, 0);
      // Move and load requested together: the load wins.
      run_op(1'b1, 1'b1, 1'b1, 5, -1);
      // Long up move runs into TAP_MAX.
      run_op(1'b1, 1'b0, 1'b1, 200, -1);

      // Random delay operations.
      for (int i = 0; i < 8; i++) begin
         ld = ($urandom_range(0, 3) == 0);
         dir = 1'($urandom);
         steps = $urandom_range(0, 12);
         lim = dir ? (TAP_MAX - model_tap) : model_tap;
         m = (steps < lim) ? steps : lim;
         oj = -1;
         if (!ld && m > 0 && $urandom_range(0, 3) == 0) oj = $urandom_range(0, m - 1);
         run_op(1'b1, ld, dir, steps, oj);
      end

      // Reset in the middle of a 6-step up move, after two pulses.
      run_op(1'b0, 1'b1, 1'b0, 0, -1);
      output_en = 1'b1;
      @(negedge clk);
      dly_req = 1'b1; dly_dir = 1'b1; dly_steps = 8'd6;
      @(posedge clk);
      @(negedge clk);
      dly_req = 1'b0;
      pulses_seen = 0;
      for (int c = 0; c < 100 && pulses_seen < 2; c++) begin
         @(negedge clk);
         if (move_0) pulses_seen++;
      end
      chk("pulses_before_reset", 32'(pulses_seen), 32'd2);
      @(negedge clk);
      arst_n = 1'b0;
      #1;
      chk_reset_values();
      @(negedge clk);
      arst_n = 1'b1;
      model_tap = DEFAULT_TAP;
      model_err = 0;
      run_op(1'b1, 1'b0, 1'b1, 4, -1);
      dp_step(1'b1, 4'b1010, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
